reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rstn  in  1  asynchronous reset, active-low.
REQ-003 src_valid[2:0]  in  3  result-valid per source: 0=load, 1=fpu, 2=alu.
REQ-004 src_ready[2:0]  out  3  result accepted this cycle, per source.
REQ-005 src_fmode[2:0], src_reg[3*5-1:0], src_data[3*32-1:0]  in  target file (1=freg), register index and data per source.
REQ-006 iss_valid, iss_fmode, iss_reg[4:0]  in  1/1/5  instruction issue; marks destination pending.
REQ-007 rfmode1, rreg1[4:0], rfmode2, rreg2[4:0]  in  1/5 each  operand lookup, same encoding as the register-file read ports.
REQ-008 busy1, busy2  out  1 each  looked-up register has a write outstanding.
REQ-009 fwd_hit1, fwd_hit2, fwd_data1[31:0], fwd_data2[31:0]  out  forwarding (see Configuration).
REQ-010 wenable, wfmode, wreg[4:0], wdata[31:0]  out  1/1/5/32  register-file write port, all registered.

Function
REQ-011 Arbitration SHALL be fixed priority load > fpu > alu; src_ready[i]=src_valid[i] and no lower-index source valid; combinational, at most one ready per cycle.
REQ-012 Transfer on source i occurs in cycle N when src_valid[i]&src_ready[i]; src_valid/fields held stable by the source until ready.
REQ-013 Transfer in cycle N SHALL drive wenable=1 with that source's fmode/reg/data in cycle N+1; no transfer in N gives wenable=0 in N+1.
REQ-014 Transfer with fmode=0 and reg=0 SHALL be accepted (ready=1) but produce wenable=0 in N+1.
REQ-015 Scoreboard: 64 pending bits (32 greg, 32 freg), one per register.
REQ-016 iss_valid in cycle N SHALL set pending[iss_fmode][iss_reg] at end of N; greg 0 never set.
REQ-017 wenable=1 in cycle M SHALL clear pending[wfmode][wreg] at end of M.
REQ-018 Set and clear to the same register at the same edge: set wins (bit stays 1).
REQ-019 busyK = pending[rfmodeK][rregK], combinational; greg 0 always reads busy=0.
REQ-020 Issue to a register already pending is legal; bit stays 1, cleared by the first subsequent write.
REQ-021 Write arriving for a non-pending register is legal; write performed, bit stays 0.

Reset
REQ-022 rstn low SHALL asynchronously force wenable=0, wfmode=0, wreg=0, wdata=0 and all 64 pending bits to 0.
REQ-023 src_ready and busy outputs SHALL follow their combinational definitions during reset (busy=0); transfers during reset are discarded.
REQ-024 Reset mid-operation: a write registered but not yet presented SHALL be lost; first possible wenable is the cycle after the first post-reset transfer.

Configuration
REQ-025 Macro WB_FORWARD_EN.
REQ-026 Defined: when wenable=1 and {wfmode,wreg}=={rfmodeK,rregK} (excluding greg 0), fwd_hitK=1, fwd_dataK=wdata, busyK=0 that cycle.
REQ-027 Undefined: fwd_hitK=0, fwd_dataK=0 constant; busyK reflects pending bit only (stays 1 through the write cycle).

Verification
REQ-028 Reset, iss f5; load writes f5=0x3F800000 cycle 2 -> wenable cycle 3 wfmode=1 wreg=5 wdata=0x3F800000; busy(f5)=0 cycle 4.
REQ-029 All three sources valid cycle 1 (g1,g2,g3) -> ready order load(c1), fpu(c2), alu(c3); writes g1,g2,g3 in cycles 2,3,4.
REQ-030 alu writes g0=0xDEADBEEF -> src_ready=1, wenable stays 0; busy(g0)=0 throughout.
REQ-031 iss g7 same cycle wenable writes g7 -> pending g7 remains 1; busy(g7)=1 next cycle.
REQ-032 With WB_FORWARD_EN, rreg1=g4 during wenable g4=0x12345678 -> fwd_hit1=1, fwd_data1=0x12345678, busy1=0; without -> fwd_hit1=0, busy1=1.
REQ-033 Assert rstn=0 mid-cycle with g9 pending and write registered -> wenable=0 and busy(g9)=0 immediately, before next edge.

Source files
------------

// File: rtl/reg_writeback_if.sv
// ============================================================================
//  reg_writeback_if
//  Result-source bus into the writeback arbiter: per-source valid, ready,
//  target file, register index and data (index 0=load, 1=fpu, 2=alu).
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_writeback_if;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [2:0]  src_fmode;
    logic [14:0] src_reg;
    logic [95:0] src_data;

    modport master (
        output src_valid,
        output src_fmode,
        output src_reg,
        output src_data,
        input  src_ready
    );

    modport slave (
        input  src_valid,
        input  src_fmode,
        input  src_reg,
        input  src_data,
        output src_ready
    );
endinterface

`default_nettype wire

// File: rtl/reg_writeback.sv
// ============================================================================
//  reg_writeback
//  Fixed-priority writeback arbiter with a 64-entry pending scoreboard.
//  Optional operand forwarding is enabled by defining WB_FORWARD_EN.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module reg_writeback (
    input  wire logic        clk,
    input  wire logic        rstn,
    reg_writeback_if.slave   src,
    input  wire logic        iss_valid,
    input  wire logic        iss_fmode,
    input  wire logic [4:0]  iss_reg,
    input  wire logic        rfmode1,
    input  wire logic [4:0]  rreg1,
    input  wire logic        rfmode2,
    input  wire logic [4:0]  rreg2,
    output logic             busy1,
    output logic             busy2,
    output logic             fwd_hit1,
    output logic             fwd_hit2,
    output logic [31:0]      fwd_data1,
    output logic [31:0]      fwd_data2,
    output logic             wenable,
    output logic             wfmode,
    output logic [4:0]       wreg,
    output logic [31:0]      wdata
);

    localparam int NUM_SRC = 3;

    logic [2:0]  grant;
    logic        xfer;
    logic        sel_fmode;
    logic [4:0]  sel_reg;
    logic [31:0] sel_data;

    logic        wenable_q, wenable_d;
    logic        wfmode_q,  wfmode_d;
    logic [4:0]  wreg_q,    wreg_d;
    logic [31:0] wdata_q,   wdata_d;

    logic [31:0] pend_g_q, pend_g_d;
    logic [31:0] pend_f_q, pend_f_d;

    logic        look_ok1, look_ok2;
    logic        pend_bit1, pend_bit2;
    logic        hit1, hit2;

    // Lowest index wins: load beats fpu beats alu.
    always_comb begin
        grant = 3'b000;
        if (src.src_valid[0]) begin
            grant = 3'b001;
        end else if (src.src_valid[1]) begin
            grant = 3'b010;
        end else if (src.src_valid[2]) begin
            grant = 3'b100;
        end
    end

    assign src.src_ready = grant;
    assign xfer          = |grant;

    always_comb begin
        sel_fmode = 1'b0;
        sel_reg   = 5'd0;
        sel_data  = 32'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_fmode = src.src_fmode[i];
                sel_reg   = src.src_reg[i*5 +: 5];
                sel_data  = src.src_data[i*32 +: 32];
            end
        end
    end

    // A transfer to greg 0 is consumed but never reaches the register file.
    always_comb begin
        wenable_d = xfer && (sel_fmode || (sel_reg != 5'd0));
        wfmode_d  = xfer ? sel_fmode : wfmode_q;
        wreg_d    = xfer ? sel_reg   : wreg_q;
        wdata_d   = xfer ? sel_data  : wdata_q;
    end

    // Clear first, then set, so an issue on the same edge as a write wins.
    always_comb begin
        pend_g_d = pend_g_q;
        pend_f_d = pend_f_q;
        if (wenable_q) begin
            if (wfmode_q) begin
                pend_f_d[wreg_q] = 1'b0;
            end else begin
                pend_g_d[wreg_q] = 1'b0;
            end
        end
        if (iss_valid) begin
            if (iss_fmode) begin
                pend_f_d[iss_reg] = 1'b1;
            end else begin
                pend_g_d[iss_reg] = 1'b1;
            end
        end
        pend_g_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wenable_q <= 1'b0;
            wfmode_q  <= 1'b0;
            wreg_q    <= 5'd0;
            wdata_q   <= 32'd0;
            pend_g_q  <= 32'd0;
            pend_f_q  <= 32'd0;
        end else begin
            wenable_q <= wenable_d;
            wfmode_q  <= wfmode_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            pend_g_q  <= pend_g_d;
            pend_f_q  <= pend_f_d;
        end
    end

    assign wenable = wenable_q;
    assign wfmode  = wfmode_q;
    assign wreg    = wreg_q;
    assign wdata   = wdata_q;

    assign look_ok1  = rfmode1 || (rreg1 != 5'd0);
    assign look_ok2  = rfmode2 || (rreg2 != 5'd0);
    assign pend_bit1 = rfmode1 ? pend_f_q[rreg1] : pend_g_q[rreg1];
    assign pend_bit2 = rfmode2 ? pend_f_q[rreg2] : pend_g_q[rreg2];

`ifdef WB_FORWARD_EN
    assign hit1 = wenable_q && (wfmode_q == rfmode1) && (wreg_q == rreg1) && look_ok1;
    assign hit2 = wenable_q && (wfmode_q == rfmode2) && (wreg_q == rreg2) && look_ok2;

    assign fwd_hit1  = hit1;
    assign fwd_hit2  = hit2;
    assign fwd_data1 = hit1 ? wdata_q : 32'd0;
    assign fwd_data2 = hit2 ? wdata_q : 32'd0;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;

    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = 32'd0;
    assign fwd_data2 = 32'd0;
`endif

    // A forwarded operand is not busy: the value is on the write port now.
    assign busy1 = pend_bit1 && look_ok1 && !hit1;
    assign busy2 = pend_bit2 && look_ok2 && !hit2;

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ============================================================================
//  tb_reg_writeback
//  Directed scenarios plus a randomized run against a queue/array model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_writeback;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        iss_valid, iss_fmode;
    logic [4:0]  iss_reg;
    logic        rfmode1, rfmode2;
    logic [4:0]  rreg1, rreg2;
    logic        busy1, busy2, fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic        wenable, wfmode;
    logic [4:0]  wreg;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    reg_writeback_if bus ();

    reg_writeback dut (
        .clk       (clk),
        .rstn      (rstn),
        .src       (bus),
        .iss_valid (iss_valid),
        .iss_fmode (iss_fmode),
        .iss_reg   (iss_reg),
        .rfmode1   (rfmode1),
        .rreg1     (rreg1),
        .rfmode2   (rfmode2),
        .rreg2     (rreg2),
        .busy1     (busy1),
        .busy2     (busy2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .wenable   (wenable),
        .wfmode    (wfmode),
        .wreg      (wreg),
        .wdata     (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, actual=running required=done");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.src_valid = 3'b000;
        bus.src_fmode = 3'b000;
        bus.src_reg   = 15'd0;
        bus.src_data  = 96'd0;
        iss_valid = 1'b0; iss_fmode = 1'b0; iss_reg = 5'd0;
        rfmode1 = 1'b0; rreg1 = 5'd0; rfmode2 = 1'b0; rreg2 = 5'd0;
    endtask

    task automatic set_src(input int i, input logic f, input logic [4:0] r, input logic [31:0] d);
        bus.src_valid[i]        = 1'b1;
        bus.src_fmode[i]        = f;
        bus.src_reg[i*5 +: 5]   = r;
        bus.src_data[i*32 +: 32] = d;
    endtask

    task automatic test_reset();
        idle();
        rstn = 1'b0;
        bus.src_valid = 3'b110;
        rfmode1 = 1'b1; rreg1 = 5'd5;
        tick();
        #1;
        checks++; if (src_ready_v() !== 3'b010) begin errors++; $display("FAIL reset_ready actual=%b required=010", src_ready_v()); end
        tick();
        checks++; if ({wenable, wfmode, wreg, wdata} !== 39'd0) begin errors++; $display("FAIL reset_wport actual=%h required=0", {wenable, wfmode, wreg, wdata}); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", busy1); end
        rstn = 1'b1;
        idle();
        tick();
        checks++; if (wenable !== 1'b0) begin errors++; $display("FAIL reset_discard actual=%b required=0", wenable); end
    endtask

    function automatic logic [2:0] src_ready_v();
        return bus.src_ready;
    endfunction

    task automatic test_load_freg();
        idle();
        iss_valid = 1'b1; iss_fmode = 1'b1; iss_reg = 5'd5;
        tick();
        idle();
        set_src(0, 1'b1, 5'd5, 32'h3F800000);
        rfmode1 = 1'b1; rreg1 = 5'd5;
        #1;
        checks++; if (bus.src_ready !== 3'b001) begin errors++; $display("FAIL f5_ready actual=%b required=001", bus.src_ready); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL f5_busy_pend actual=%b required=1", busy1); end
        tick();
        bus.src_valid = 3'b000;
        #1;
        checks++; if ({wenable, wfmode, wreg, wdata} !== {1'b1, 1'b1, 5'd5, 32'h3F800000}) begin
            errors++; $display("FAIL f5_write actual=%b/%b/%0d/%h required=1/1/5/3f800000", wenable, wfmode, wreg, wdata); end
        checks++; if (busy1 !== !FWD || fwd_hit1 !== FWD) begin
            errors++; $display("FAIL f5_wcycle actual=busy%b hit%b required=busy%b hit%b", busy1, fwd_hit1, !FWD, FWD); end
        tick();
        checks++; if (busy1 !== 1'b0 || wenable !== 1'b0) begin errors++; $display("FAIL f5_after actual=busy%b wen%b required=0/0", busy1, wenable); end
    endtask

    task automatic test_priority();
        logic [2:0]  exp_rdy [3];
        exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
        idle();
        set_src(0, 1'b0, 5'd1, 32'h11);
        set_src(1, 1'b0, 5'd2, 32'h22);
        set_src(2, 1'b0, 5'd3, 32'h33);
        for (int c = 0; c < 4; c++) begin
            #1;
            if (c < 3) begin
                checks++; if (bus.src_ready !== exp_rdy[c]) begin errors++; $display("FAIL prio_ready%0d actual=%b required=%b", c, bus.src_ready, exp_rdy[c]); end
            end
            if (c > 0) begin
                checks++; if ({wenable, wfmode, wreg, wdata} !== {1'b1, 1'b0, 5'(c), 32'(c * 17)}) begin
                    errors++; $display("FAIL prio_write%0d actual=%b/%0d/%h required=1/%0d/%h", c, wenable, wreg, wdata, c, c * 17); end
            end
            tick();
            if (c < 3) bus.src_valid[c] = 1'b0;
        end
        #1;
        checks++; if (wenable !== 1'b0) begin errors++; $display("FAIL prio_idle actual=%b required=0", wenable); end
    endtask

    task automatic test_greg_zero();
        idle();
        set_src(2, 1'b0, 5'd0, 32'hDEADBEEF);
        iss_valid = 1'b1; iss_reg = 5'd0;
        #1;
        checks++; if (bus.src_ready !== 3'b100 || busy1 !== 1'b0) begin errors++; $display("FAIL g0_accept actual=rdy%b busy%b required=100/0", bus.src_ready, busy1); end
        tick();
        idle();
        #1;
        checks++; if (wenable !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL g0_nowrite actual=wen%b busy%b required=0/0", wenable, busy1); end
        tick();
    endtask

    task automatic test_set_clear();
        idle();
        iss_valid = 1'b1; iss_reg = 5'd7;
        tick();
        idle();
        set_src(2, 1'b0, 5'd7, 32'h77);
        tick();
        idle();
        iss_valid = 1'b1; iss_reg = 5'd7;
        #1;
        checks++; if (wenable !== 1'b1 || wreg !== 5'd7) begin errors++; $display("FAIL g7_write actual=%b/%0d required=1/7", wenable, wreg); end
        tick();
        idle();
        rreg1 = 5'd7;
        set_src(2, 1'b0, 5'd7, 32'h78);
        #1;
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL g7_setwins actual=%b required=1", busy1); end
        tick();
        bus.src_valid = 3'b000;
        tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL g7_cleared actual=%b required=0", busy1); end
    endtask

    task automatic test_forward();
        idle();
        iss_valid = 1'b1; iss_reg = 5'd4;
        tick();
        idle();
        set_src(1, 1'b0, 5'd4, 32'h12345678);
        tick();
        idle();
        rfmode1 = 1'b0; rreg1 = 5'd4;
        rfmode2 = 1'b1; rreg2 = 5'd4;
        #1;
        checks++; if (fwd_hit1 !== FWD || busy1 !== !FWD) begin errors++; $display("FAIL fwd_hit1 actual=hit%b busy%b required=hit%b busy%b", fwd_hit1, busy1, FWD, !FWD); end
        checks++; if (fwd_data1 !== (FWD ? 32'h12345678 : 32'h0)) begin errors++; $display("FAIL fwd_data1 actual=%h required=%h", fwd_data1, FWD ? 32'h12345678 : 32'h0); end
        checks++; if (fwd_hit2 !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL fwd_other_file actual=hit%b busy%b required=0/0", fwd_hit2, busy2); end
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        iss_valid = 1'b1; iss_reg = 5'd9;
        tick();
        idle();
        set_src(0, 1'b0, 5'd9, 32'h99);
        tick();
        idle();
        rreg1 = 5'd9;
        set_src(2, 1'b0, 5'd10, 32'hAA);
        checks++; if (wenable !== 1'b1) begin errors++; $display("FAIL mid_pre actual=%b required=1", wenable); end
        rstn = 1'b0;
        #1;
        checks++; if ({wenable, wfmode, wreg, wdata} !== 39'd0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL mid_reset actual=wen%b reg%0d data%h busy%b required=0", wenable, wreg, wdata, busy1); end
        checks++; if (bus.src_ready !== 3'b100) begin errors++; $display("FAIL mid_ready actual=%b required=100", bus.src_ready); end
        tick();
        #2;
        rstn = 1'b1;
        bus.src_valid = 3'b000;
        tick();
        checks++; if (wenable !== 1'b0) begin errors++; $display("FAIL mid_lost actual=%b required=0", wenable); end
        set_src(2, 1'b0, 5'd10, 32'hAA);
        tick();
        bus.src_valid = 3'b000;
        checks++; if (wenable !== 1'b1 || wreg !== 5'd10) begin errors++; $display("FAIL mid_first actual=%b/%0d required=1/10", wenable, wreg); end
        tick();
    endtask

    task automatic test_random();
        bit          pend [2][32];
        bit          act  [3];
        logic        sf   [3];
        logic [4:0]  sr   [3];
        logic [31:0] sd   [3];
        bit          m_wen;
        logic        m_wf;
        logic [4:0]  m_wr;
        logic [31:0] m_wd;
        int          win;
        logic [2:0]  e_rdy;
        bit          ok1, ok2, h1, h2, eb1, eb2;

        idle();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        foreach (pend[f, r]) pend[f][r] = 1'b0;
        foreach (act[i]) act[i] = 1'b0;
        m_wen = 1'b0; m_wf = 1'b0; m_wr = 5'd0; m_wd = 32'd0;

        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (!act[i] && ($urandom % 3 == 0)) begin
                    act[i] = 1'b1;
                    sf[i] = 1'($urandom);
                    sr[i] = 5'($urandom_range(0, 7));
                    sd[i] = $urandom;
                end
                bus.src_valid[i] = act[i];
                if (act[i]) set_src(i, sf[i], sr[i], sd[i]);
            end
            iss_valid = ($urandom % 3 == 0);
            iss_fmode = 1'($urandom);
            iss_reg   = 5'($urandom_range(0, 7));
            rfmode1 = 1'($urandom); rreg1 = 5'($urandom_range(0, 7));
            rfmode2 = 1'($urandom); rreg2 = 5'($urandom_range(0, 7));
            #1;

            win = -1;
            for (int i = 2; i >= 0; i--) if (act[i]) win = i;
            e_rdy = (win >= 0) ? 3'(1 << win) : 3'b000;
            ok1 = rfmode1 || (rreg1 != 0);
            ok2 = rfmode2 || (rreg2 != 0);
            h1 = FWD && m_wen && (m_wf == rfmode1) && (m_wr == rreg1) && ok1;
            h2 = FWD && m_wen && (m_wf == rfmode2) && (m_wr == rreg2) && ok2;
            eb1 = ok1 && pend[rfmode1][rreg1] && !h1;
            eb2 = ok2 && pend[rfmode2][rreg2] && !h2;

            checks++; if (bus.src_ready !== e_rdy) begin errors++; $display("FAIL rnd_ready c%0d actual=%b required=%b", cyc, bus.src_ready, e_rdy); end
            checks++; if (wenable !== m_wen) begin errors++; $display("FAIL rnd_wen c%0d actual=%b required=%b", cyc, wenable, m_wen); end
            if (m_wen) begin
                checks++; if ({wfmode, wreg, wdata} !== {m_wf, m_wr, m_wd}) begin
                    errors++; $display("FAIL rnd_wport c%0d actual=%b/%0d/%h required=%b/%0d/%h", cyc, wfmode, wreg, wdata, m_wf, m_wr, m_wd); end
            end
            checks++; if (busy1 !== eb1 || busy2 !== eb2) begin errors++; $display("FAIL rnd_busy c%0d actual=%b%b required=%b%b", cyc, busy1, busy2, eb1, eb2); end
            checks++; if (fwd_hit1 !== h1 || fwd_hit2 !== h2) begin errors++; $display("FAIL rnd_hit c%0d actual=%b%b required=%b%b", cyc, fwd_hit1, fwd_hit2, h1, h2); end
            if (h1) begin
                checks++; if (fwd_data1 !== m_wd) begin errors++; $display("FAIL rnd_fdata1 c%0d actual=%h required=%h", cyc, fwd_data1, m_wd); end
            end
            if (h2) begin
                checks++; if (fwd_data2 !== m_wd) begin errors++; $display("FAIL rnd_fdata2 c%0d actual=%h required=%h", cyc, fwd_data2, m_wd); end
            end

            if (m_wen) pend[m_wf][m_wr] = 1'b0;
            if (iss_valid && (iss_fmode || iss_reg != 0)) pend[iss_fmode][iss_reg] = 1'b1;
            if (win >= 0) begin
                m_wen = sf[win] || (sr[win] != 0);
                m_wf  = sf[win];
                m_wr  = sr[win];
                m_wd  = sd[win];
                act[win] = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        test_reset();
        test_load_freg();
        test_priority();
        test_greg_zero();
        test_set_clear();
        test_forward();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
